montgomery_to_form_serial: RTL and testbench

MONTGOMERY_TO_FORM_SERIAL -- requirements
Module: montgomery_to_form_serial

---
 rtl/montgomery_to_form_serial.sv | 153 +++++++++++++++
 tb/tb_montgomery_to_form_serial.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/montgomery_to_form_serial.sv
// Serial Montgomery-form converter: result = (x * 2^k) mod m, one shift-and-reduce step per cycle.
// Latency: WIDTH + k cycles after the capture edge; operands that cannot be converted reach DONE in 1 cycle.
// Backpressure: none; start_i is honoured only in IDLE/DONE, and DONE holds the result until restarted.
module montgomery_to_form_serial #(
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] m_i,
  input  logic [WIDTH-1:0] m_bl_i,
  output logic [WIDTH-1:0] result_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             err_o
);

  // Counter must reach WIDTH-1 in REDUCE and up to WIDTH-1 in SCALE (k <= WIDTH).
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH + 1) : 1;
  localparam logic [CW-1:0]    RED_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] K_MAX    = WIDTH'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REDUCE = 2'd1,
    S_SCALE  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Captured operands; r_x is shifted left so its MSB is always the next bit to fold in.
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_k;
  // One spare bit: 2*acc + bit can reach 2m-1, which needs WIDTH+1 bits before the subtract.
  logic [WIDTH:0]   r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_err;

  logic             w_start;
  logic             w_in_illegal;
  logic             w_red_last;
  logic             w_scl_last;
  logic             w_bit;
  logic [WIDTH:0]   w_dbl;
  logic [WIDTH:0]   w_mext;
  logic [WIDTH:0]   w_step;

  // A new request is accepted only while no conversion is running.
  assign w_start      = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Operands that cannot be converted: zero modulus or an exponent beyond the datapath width.
  assign w_in_illegal = (m_i == '0) || (m_bl_i > K_MAX);

  assign w_red_last   = (r_cnt == RED_LAST);
  assign w_scl_last   = ((WIDTH'(r_cnt) + WIDTH'(1)) == r_k);

  // REDUCE folds in the operand MSB-first; SCALE is a pure doubling.
  assign w_bit        = (r_state == S_REDUCE) && r_x[WIDTH-1];
  assign w_dbl        = (r_acc << 1) | {{WIDTH{1'b0}}, w_bit};
  assign w_mext       = {1'b0, r_m};
  // acc < m before each step, so 2*acc + bit < 2m and a single subtract restores acc < m.
  assign w_step       = (w_dbl >= w_mext) ? (w_dbl - w_mext) : w_dbl;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state selection and state-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    valid_o     = 1'b0;
    busy_o      = 1'b0;
    err_o       = 1'b0;
    result_o    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = w_in_illegal ? S_DONE : S_REDUCE;
        end
      end
      S_REDUCE: begin
        busy_o = 1'b1;
        if (w_red_last) begin
          w_state_nxt = (r_k == '0) ? S_DONE : S_SCALE;
        end
      end
      S_SCALE: begin
        busy_o = 1'b1;
        if (w_scl_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        valid_o  = 1'b1;
        err_o    = r_err;
        result_o = r_err ? '0 : r_acc[WIDTH-1:0];
        if (w_start) begin
          w_state_nxt = w_in_illegal ? S_DONE : S_REDUCE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand capture, accumulator update and step counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_x   <= '0;
      r_m   <= '0;
      r_k   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_x   <= x_i;
            r_m   <= m_i;
            r_k   <= m_bl_i;
            r_acc <= '0;
            r_cnt <= '0;
            r_err <= w_in_illegal;
          end
        end
        S_REDUCE: begin
          r_acc <= w_step;
          r_x   <= r_x << 1;
          r_cnt <= w_red_last ? '0 : (r_cnt + CW'(1));
        end
        S_SCALE: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + CW'(1);
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_to_form_serial.sv
// Bench for montgomery_to_form_serial: random and directed conversions against an arithmetic model.
// Timing: start raised in cycle 0 is captured at edge 1; the result is expected after edge 1+WIDTH+k.
// Inputs driven and outputs sampled on the falling edge.
module tb_montgomery_to_form_serial;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] m;
  logic [W-1:0] k;
  logic [W-1:0] result;
  logic         valid;
  logic         busy;
  logic         err;

  int vectors     = 0;
  int miscompares = 0;

  montgomery_to_form_serial #(.WIDTH(W)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .x_i      (x),
    .m_i      (m),
    .m_bl_i   (k),
    .result_o (result),
    .valid_o  (valid),
    .busy_o   (busy),
    .err_o    (err)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, need finished");
    $fatal(1, "watchdog timeout");
  end

  // Reference: plain wide arithmetic, (x * 2^k) mod m.
  function automatic logic [W-1:0] ref_mod(input logic [W-1:0] rx, input logic [W-1:0] rm,
                                           input int rk);
    logic [3*W-1:0] p;
    p = {{(2*W){1'b0}}, rx} << rk;
    p = p % {{(2*W){1'b0}}, rm};
    return p[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Present a request for one cycle, then scramble the inputs (they are don't-care after capture).
  task automatic launch(input logic [W-1:0] lx, input logic [W-1:0] lm, input logic [W-1:0] lk);
    @(negedge clk);
    x = lx; m = lm; k = lk; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x = rand64(); m = rand64(); k = rand64();
  endtask

  // Count falling edges until valid; edges starts at 1 (the capture edge).
  task automatic wait_valid(input int budget, output int edges, output int nbusy);
    edges = 1;
    nbusy = 0;
    while (!valid && edges < budget) begin
      if (busy) nbusy++;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; x = 64'd3; m = 64'd17; k = 64'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({valid, busy, err, result} !== {3'b000, 64'd0}) begin
        miscompares++;
        $display("FAIL reset_hold cyc%0d: got v=%b b=%b e=%b r=%h, need all zero", i, valid, busy, err, result);
      end
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    vectors++;
    if ({valid, busy, err, result} !== {3'b000, 64'd0}) begin
      miscompares++;
      $display("FAIL reset_idle: got v=%b b=%b e=%b r=%h, need all zero", valid, busy, err, result);
    end
  endtask

  task automatic test_known();
    logic [W-1:0] tx [5];
    logic [W-1:0] tm [5];
    int           tk [5];
    logic [W-1:0] te [5];
    int edges, nbusy;
    tx = '{64'd3, 64'd100, 64'd100, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF};
    tm = '{64'd17, 64'd17, 64'd17, 64'hFFFF_FFFF_0000_0001, 64'hFFFF_FFFF_0000_0001};
    tk = '{5, 5, 0, 64, 0};
    te = '{64'd11, 64'd4, 64'd15, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFE};
    for (int i = 0; i < 5; i++) begin
      launch(tx[i], tm[i], W'(tk[i]));
      wait_valid(400, edges, nbusy);
      vectors++;
      if (edges !== 1 + W + tk[i]) begin
        miscompares++;
        $display("FAIL known%0d_latency: got %0d, need %0d", i, edges, 1 + W + tk[i]);
      end
      vectors++;
      if (nbusy !== W + tk[i]) begin
        miscompares++;
        $display("FAIL known%0d_busy: got %0d cycles, need %0d", i, nbusy, W + tk[i]);
      end
      vectors++;
      if (result !== te[i] || err !== 1'b0) begin
        miscompares++;
        $display("FAIL known%0d_result: got r=%h e=%b, need r=%h e=0", i, result, err, te[i]);
      end
      repeat (2) @(negedge clk);
      vectors++;
      if (valid !== 1'b1 || busy !== 1'b0 || result !== te[i]) begin
        miscompares++;
        $display("FAIL known%0d_hold: got v=%b b=%b r=%h, need v=1 b=0 r=%h", i, valid, busy, result, te[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [W-1:0] im [4];
    logic [W-1:0] ik [4];
    int edges, nbusy;
    logic [W-1:0] exp;
    im = '{64'd0, 64'd17, 64'd0, 64'd5};
    ik = '{64'd5, 64'd65, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      launch(rand64(), im[i], ik[i]);
      vectors++;
      if ({valid, err, busy, result} !== {3'b110, 64'd0}) begin
        miscompares++;
        $display("FAIL illegal%0d_next: got v=%b e=%b b=%b r=%h, need v=1 e=1 b=0 r=0",
                 i, valid, err, busy, result);
      end
      @(negedge clk);
      vectors++;
      if ({valid, err, result} !== {2'b11, 64'd0}) begin
        miscompares++;
        $display("FAIL illegal%0d_hold: got v=%b e=%b r=%h, need v=1 e=1 r=0", i, valid, err, result);
      end
    end
    exp = ref_mod(64'd5, 64'd7, 3);
    launch(64'd5, 64'd7, 64'd3);
    vectors++;
    if (err !== 1'b0 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_clear_now: got v=%b e=%b, need v=0 e=0", valid, err);
    end
    wait_valid(400, edges, nbusy);
    vectors++;
    if (valid !== 1'b1 || err !== 1'b0 || result !== exp || edges !== 1 + W + 3) begin
      miscompares++;
      $display("FAIL illegal_clear_result: got v=%b e=%b r=%h lat=%0d, need v=1 e=0 r=%h lat=%0d",
               valid, err, result, edges, exp, 1 + W + 3);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] rx, rm, exp;
    int rk, edges, nbusy;
    for (int i = 0; i < 30; i++) begin
      rx = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : rand64();
      case ($urandom_range(0, 3))
        0:       rm = 64'($urandom_range(1, 255));
        1:       rm = rand64();
        2:       rm = rand64() | 64'h8000_0000_0000_0000;
        default: rm = 64'd1;
      endcase
      if (rm == '0) rm = 64'd3;
      rk  = $urandom_range(0, 64);
      exp = ref_mod(rx, rm, rk);
      launch(rx, rm, W'(rk));
      wait_valid(400, edges, nbusy);
      vectors++;
      if (valid !== 1'b1 || result !== exp || err !== 1'b0 || edges !== 1 + W + rk) begin
        miscompares++;
        $display("FAIL random%0d x=%h m=%h k=%0d: got v=%b r=%h e=%b lat=%0d, need v=1 r=%h e=0 lat=%0d",
                 i, rx, rm, rk, valid, result, err, edges, exp, 1 + W + rk);
      end
    end
  endtask

  task automatic test_abort();
    int where [2];
    int seen_valid, seen_busy;
    where = '{28, W + 10};
    for (int i = 0; i < 2; i++) begin
      launch(rand64(), 64'd1_000_003, 64'd40);
      repeat (where[i]) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vectors++;
      if ({valid, busy, err, result} !== {3'b000, 64'd0}) begin
        miscompares++;
        $display("FAIL abort%0d_outputs: got v=%b b=%b e=%b r=%h, need all zero", i, valid, busy, err, result);
      end
      seen_valid = 0;
      seen_busy  = 0;
      for (int c = 0; c < 150; c++) begin
        @(negedge clk);
        if (valid) seen_valid++;
        if (busy)  seen_busy++;
      end
      vectors++;
      if (seen_valid !== 0 || seen_busy !== 0) begin
        miscompares++;
        $display("FAIL abort%0d_quiet: got valid=%0d busy=%0d cycles, need 0 and 0", i, seen_valid, seen_busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] bx, bm, exp;
    int bk, edges, nbusy;
    launch(64'd77, 64'd101, 64'd9);
    wait_valid(400, edges, nbusy);
    exp = ref_mod(64'd77, 64'd101, 9);
    vectors++;
    if (valid !== 1'b1 || result !== exp) begin
      miscompares++;
      $display("FAIL b2b_first: got v=%b r=%h, need v=1 r=%h", valid, result, exp);
    end
    for (int j = 0; j < 3; j++) begin
      bx  = rand64();
      bm  = rand64() | 64'd1;
      bk  = $urandom_range(0, 64);
      exp = ref_mod(bx, bm, bk);
      x = bx; m = bm; k = W'(bk); start = 1'b1;
      @(negedge clk);
      vectors++;
      if (valid !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b%0d_restart: got v=%b b=%b, need v=0 b=1", j, valid, busy);
      end
      edges = 1;
      while (!valid && edges < 400) begin
        start = 1'($urandom_range(0, 1));
        x = rand64(); m = ($urandom_range(0, 1) == 1) ? 64'd0 : rand64(); k = rand64();
        @(negedge clk);
        edges++;
      end
      start = 1'b0;
      vectors++;
      if (valid !== 1'b1 || result !== exp || err !== 1'b0 || edges !== 1 + W + bk) begin
        miscompares++;
        $display("FAIL b2b%0d_result: got v=%b r=%h e=%b lat=%0d, need v=1 r=%h e=0 lat=%0d",
                 j, valid, result, err, edges, exp, 1 + W + bk);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; x = '0; m = '0; k = '0;
    test_reset();
    test_known();
    test_illegal();
    test_random();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
